simple_cpu: RTL and testbench

Minimal multi-cycle, non-pipelined CPU core with a 4-entry register file and an internal data memory. It executes one externally supplied 20-bit instruction every three clocks: register-register ADD/SUB/AND/OR, plus base+offset LOAD/STORE. It is a stand-alone teaching/prototype core with no instruction memory or program counter. The surrounding test environment drives `instruction` directly and observes state hierarchically.

---
 rtl/simple_cpu_pkg.sv | 31 +++
 rtl/simple_cpu_alu.sv | 26 ++
 rtl/simple_cpu.sv | 118 +++++++++++
 tb/tb_simple_cpu.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/simple_cpu_pkg.sv
// Shared encodings for simple_cpu: instruction types, ALU functions, FSM states, field positions.
// Fields are fixed for a 20-bit instruction word.
package simple_cpu_pkg;

  typedef enum logic [1:0] {
    TYPE_NOP   = 2'b00,
    TYPE_ALU   = 2'b01,
    TYPE_LOAD  = 2'b10,
    TYPE_STORE = 2'b11
  } instr_type_e;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_e;

  localparam int TYPE_LSB = 18;
  localparam int X1_LSB   = 16;
  localparam int X2_LSB   = 14;
  localparam int X3_LSB   = 12;
  localparam int IMM_LSB  = 4;
  localparam int IMM_W    = 8;
  localparam int FN_LSB   = 0;

endpackage

// File: rtl/simple_cpu_alu.sv
// Combinational ADD/SUB/AND/OR unit, zero latency; vld_o low for unused function codes.
module simple_cpu_alu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [3:0]            fn_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  vld_o
);

  always_comb begin
    res_o = '0;
    vld_o = 1'b1;
    case (fn_i)
      FN_ADD:  res_o = a_i + b_i;
      FN_SUB:  res_o = a_i - b_i;
      FN_AND:  res_o = a_i & b_i;
      FN_OR:   res_o = a_i | b_i;
      default: vld_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/simple_cpu.sv
// Multi-cycle core: FETCH/DECODE/EXEC, one instruction per 3 clocks, state visible 2 edges after fetch.
// No handshake; the instruction input is sampled only in FETCH.
module simple_cpu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input logic                   clk,
  input logic                   rst,
  input logic [INSTR_WIDTH-1:0] instruction
);

  localparam int MEM_WORDS = 1 << ADDR_BITS;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0]  op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]  op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0]  op_s_q, op_s_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;

  logic [DATA_WIDTH-1:0]  reg_file [0:3];
  logic [DATA_WIDTH-1:0]  data_mem [0:MEM_WORDS-1];

  instr_type_e            ityp;
  logic [1:0]             x1, x2, x3;
  logic [IMM_W-1:0]       imm8;
  logic [3:0]             fn;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_vld;
  logic                   reg_we, mem_we;
  logic [DATA_WIDTH-1:0]  reg_wdat;

  assign ityp = instr_type_e'(ir_q[TYPE_LSB +: 2]);
  assign x1   = ir_q[X1_LSB +: 2];
  assign x2   = ir_q[X2_LSB +: 2];
  assign x3   = ir_q[X3_LSB +: 2];
  assign imm8 = ir_q[IMM_LSB +: IMM_W];
  assign fn   = ir_q[FN_LSB +: 4];

  simple_cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i  (op_a_q),
    .b_i  (op_b_q),
    .fn_i (fn),
    .res_o(alu_res),
    .vld_o(alu_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_s_d   = op_s_q;
    addr_d   = addr_q;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    reg_wdat = '0;
    case (state_q)
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_a_d  = reg_file[x2];
        op_b_d  = reg_file[x3];
        op_s_d  = reg_file[x1];
        // Sum is taken at register width, then truncated: address wraps modulo memory size.
        addr_d  = ADDR_BITS'(reg_file[x2] + DATA_WIDTH'(imm8));
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ityp)
          TYPE_ALU: begin
            reg_we   = alu_vld;
            reg_wdat = alu_res;
          end
          TYPE_LOAD: begin
            reg_we   = 1'b1;
            reg_wdat = data_mem[addr_q];
          end
          TYPE_STORE: mem_we = 1'b1;
          default: ;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ir_q   <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_s_q <= '0;
      addr_q <= '0;
      for (int i = 0; i < 4; i++) reg_file[i] <= DATA_WIDTH'(i);
      for (int j = 0; j < MEM_WORDS; j++) data_mem[j] <= '0;
    end else begin
      ir_q   <= ir_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      op_s_q <= op_s_d;
      addr_q <= addr_d;
      if (reg_we) reg_file[x1] <= reg_wdat;
      if (mem_we) data_mem[addr_q] <= op_s_q;
    end
  end

endmodule

// File: tb/tb_simple_cpu.sv
// Bench for simple_cpu: directed instructions queue expected register/memory values,
// a monitor checks them after every completed EXEC edge or reset release.
module tb_simple_cpu;
  import simple_cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [19:0] instruction;

  typedef struct {
    bit         is_mem;
    logic [4:0] idx;
    logic [7:0] val;
    string      name;
    bit         last;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  simple_cpu #(.DATA_WIDTH(8), .ADDR_BITS(5), .INSTR_WIDTH(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input bit is_mem, input logic [4:0] idx, input logic [7:0] val,
                          input string name, input bit last);
    exp_t e;
    e.is_mem = is_mem;
    e.idx    = idx;
    e.val    = val;
    e.name   = name;
    e.last   = last;
    exp_q.push_back(e);
  endtask

  task automatic expect_reset(input string tag);
    for (int i = 0; i < 4; i++) expect_v(1'b0, 5'(i), 8'(i), {tag, "_reg"}, 1'b0);
    expect_v(1'b1, 5'd1,  8'h00, {tag, "_mem1"},  1'b0);
    expect_v(1'b1, 5'd17, 8'h00, {tag, "_mem17"}, 1'b0);
    expect_v(1'b1, 5'd24, 8'h00, {tag, "_mem24"}, 1'b1);
  endtask

  // Called at posedge+2; returns at posedge+2 after the EXEC edge.
  task automatic issue(input logic [19:0] instr);
    instruction = instr;
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic issue_glitch(input logic [19:0] instr, input logic [19:0] other);
    instruction = instr;
    @(posedge clk);
    #2 instruction = other;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    expect_reset(tag);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic issue_abort(input logic [19:0] instr);
    instruction = instr;
    @(posedge clk);
    #2;
    do_reset("abort");
  endtask

  // Monitor: a group completes when an EXEC edge passed with reset high, or reset just released.
  initial begin
    state_e     prev_state;
    logic       prev_rst;
    logic       cur_rst;
    logic [7:0] actual;
    exp_t       e;
    bit         done;
    prev_state = S_FETCH;
    prev_rst   = 1'b0;
    forever begin
      @(negedge clk);
      cur_rst = rst;
      if ((prev_state == S_EXEC && prev_rst) || (!prev_rst && cur_rst)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_completion actual=completion required=none t=%0t", $time);
        end else begin
          done = 1'b0;
          while (!done && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            actual = e.is_mem ? dut.data_mem[e.idx] : dut.reg_file[e.idx[1:0]];
            total++;
            if (actual !== e.val) begin
              bad++;
              $display("FAIL %s idx=%0d actual=%h required=%h", e.name, e.idx, actual, e.val);
            end
            done = e.last;
          end
        end
      end
      prev_state = dut.state_q;
      prev_rst   = cur_rst;
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    instruction = '0;
    expect_reset("reset0");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    expect_v(0, 0, 8'h04, "add_r0", 0);
    expect_v(0, 1, 8'h01, "add_r1", 0);
    expect_v(0, 2, 8'h02, "add_r2", 0);
    expect_v(0, 3, 8'h03, "add_r3", 1);
    issue(20'h47000);
    expect_v(0, 1, 8'h07, "add2_r1", 1);
    issue(20'h53000);
    expect_v(0, 3, 8'h02, "sub_r3", 0);
    expect_v(0, 0, 8'h04, "sub_r0", 1);
    issue(20'h72001);
    expect_v(1, 17, 8'h07, "store_m17", 1);
    issue(20'hD80F0);
    expect_v(1, 24, 8'h04, "store_m24", 0);
    expect_v(1, 17, 8'h07, "store_m17_kept", 1);
    issue(20'hCC160);
    expect_v(0, 3, 8'h07, "load_r3", 1);
    issue(20'hB80F0);
    expect_v(0, 2, 8'h04, "and_r2", 1);
    issue(20'h61002);
    expect_v(0, 1, 8'h03, "sub_self_r1", 1);
    issue(20'h54001);
    expect_v(0, 0, 8'h07, "or_self_r0", 1);
    issue(20'h41003);
    expect_v(0, 0, 8'h07, "badfn_r0", 0);
    expect_v(0, 1, 8'h03, "badfn_r1", 0);
    expect_v(0, 2, 8'h04, "badfn_r2", 0);
    expect_v(0, 3, 8'h07, "badfn_r3", 1);
    issue(20'h41005);
    expect_v(0, 0, 8'h07, "nop_r0", 0);
    expect_v(0, 1, 8'h03, "nop_r1", 0);
    expect_v(0, 2, 8'h04, "nop_r2", 0);
    expect_v(0, 3, 8'h07, "nop_r3", 0);
    expect_v(1, 17, 8'h07, "nop_m17", 0);
    expect_v(1, 24, 8'h04, "nop_m24", 1);
    issue(20'h3F123);

    do_reset("reset1");
    expect_v(0, 0, 8'hFD, "subwrap_r0", 0);
    expect_v(0, 3, 8'h03, "subwrap_r3", 1);
    issue(20'h43001);
    expect_v(1, 1, 8'hFD, "storewrap_m1", 1);
    issue(20'hCC1E0);
    expect_v(0, 2, 8'hFD, "loadwrap_r2", 1);
    issue(20'hA0040);
    expect_v(0, 3, 8'h04, "latched_r3", 0);
    expect_v(0, 0, 8'hFD, "latched_r0", 1);
    issue_glitch(20'h77000, 20'h43001);

    issue_abort(20'h47000);
    expect_v(0, 0, 8'hFF, "rerun1_r0", 1);
    issue(20'h41001);
    expect_v(0, 0, 8'hFE, "rerun2_r0", 0);
    expect_v(0, 1, 8'h01, "rerun2_r1", 1);
    issue(20'h41001);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_expectations actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
